// File: rtl/i2c_master_bit_ctrl_if.sv
// Bit-level I2C master interface: byte-controller handshake plus the open-drain
// bus pins. Signal suffixes are from the bit controller's point of view.
interface i2c_master_bit_ctrl_if;
   logic [15:0] clk_cnt_i;   // quarter-bit prescale
   logic [3:0]  bit_cmd_i;   // one-hot command
   logic        bit_txd_i;   // bit to send with WRITE
   logic        bit_ack_o;   // command complete pulse
   logic        bit_rxd_o;   // bit sampled in phase C of READ/WRITE
   logic        i2c_al_o;    // arbitration lost pulse
   logic        busy_o;      // command in progress
   logic        scl_i;       // SCL line level (asynchronous)
   logic        sda_i;       // SDA line level (asynchronous)
   logic        scl_oen_o;   // 1 releases SCL, 0 pulls it low
   logic        sda_oen_o;   // 1 releases SDA, 0 pulls it low

   modport slave (
      input  clk_cnt_i, bit_cmd_i, bit_txd_i, scl_i, sda_i,
      output bit_ack_o, bit_rxd_o, i2c_al_o, busy_o, scl_oen_o, sda_oen_o
   );

   modport master (
      output clk_cnt_i, bit_cmd_i, bit_txd_i,
      input  bit_ack_o, bit_rxd_o, i2c_al_o, busy_o, scl_oen_o, sda_oen_o
   );
endinterface

// File: rtl/i2c_master_bit_ctrl.sv
// I2C master bit controller: turns one-hot START/STOP/WRITE/READ commands into
// four quarter-bit phases on SCL/SDA, with clock stretching and arbitration
// loss detection. Every bus output comes straight from a flop.
module i2c_master_bit_ctrl #(
   parameter int unsigned SYNC_STAGES = 2   // 2 or 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   i2c_master_bit_ctrl_if.slave bus
);

   typedef enum logic [4:0] {
      ST_IDLE    = 5'd0,
      ST_START_A = 5'd1,  ST_START_B = 5'd2,  ST_START_C = 5'd3,  ST_START_D = 5'd4,
      ST_STOP_A  = 5'd5,  ST_STOP_B  = 5'd6,  ST_STOP_C  = 5'd7,  ST_STOP_D  = 5'd8,
      ST_WR_A    = 5'd9,  ST_WR_B    = 5'd10, ST_WR_C    = 5'd11, ST_WR_D    = 5'd12,
      ST_RD_A    = 5'd13, ST_RD_B    = 5'd14, ST_RD_C    = 5'd15, ST_RD_D    = 5'd16
   } state_t;

   localparam logic [3:0] CMD_START = 4'b0001;
   localparam logic [3:0] CMD_STOP  = 4'b0010;
   localparam logic [3:0] CMD_WRITE = 4'b0100;
   localparam logic [3:0] CMD_READ  = 4'b1000;

   state_t                 state_q, state_d;
   logic [15:0]            cnt_q, cnt_d;
   logic                   txd_q, txd_d;
   logic                   rxd_q, rxd_d;
   logic                   ack_q, ack_d;
   logic                   al_q, al_d;
   logic                   busy_q, busy_d;
   logic                   scl_oen_q, scl_oen_d;
   logic                   sda_oen_q, sda_oen_d;
   logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
   logic [SYNC_STAGES-1:0] scl_rel_q, sda_rel_q;

   logic scl_s, sda_s;
   logic scl_settled_s, sda_settled_s;
   logic phase_bc_s, freeze_s, tick_s, arb_lost_s, cmd_valid_s, accept_s;

   // First phase of the accepted command.
   function automatic state_t first_state(input logic [3:0] cmd);
      state_t s;
      case (cmd)
         CMD_START: s = ST_START_A;
         CMD_STOP:  s = ST_STOP_A;
         CMD_WRITE: s = ST_WR_A;
         CMD_READ:  s = ST_RD_A;
         default:   s = ST_IDLE;
      endcase
      return s;
   endfunction

   // Phase sequencing: A->B->C->D, D back to IDLE.
   function automatic state_t next_phase(input state_t s);
      state_t n;
      case (s)
         ST_START_A: n = ST_START_B;
         ST_START_B: n = ST_START_C;
         ST_START_C: n = ST_START_D;
         ST_STOP_A:  n = ST_STOP_B;
         ST_STOP_B:  n = ST_STOP_C;
         ST_STOP_C:  n = ST_STOP_D;
         ST_WR_A:    n = ST_WR_B;
         ST_WR_B:    n = ST_WR_C;
         ST_WR_C:    n = ST_WR_D;
         ST_RD_A:    n = ST_RD_B;
         ST_RD_B:    n = ST_RD_C;
         ST_RD_C:    n = ST_RD_D;
         default:    n = ST_IDLE;
      endcase
      return n;
   endfunction

   // Line enables {scl, sda} for a phase; consecutive phases differ in one line only.
   function automatic logic [1:0] line_drive(input state_t s, input logic txd);
      logic [1:0] d;
      case (s)
         ST_START_A, ST_START_B: d = 2'b11;
         ST_START_C:             d = 2'b10;
         ST_START_D:             d = 2'b00;
         ST_STOP_A:              d = 2'b00;
         ST_STOP_B, ST_STOP_C:   d = 2'b10;
         ST_STOP_D:              d = 2'b11;
         ST_WR_A, ST_WR_D:       d = {1'b0, txd};
         ST_WR_B, ST_WR_C:       d = {1'b1, txd};
         ST_RD_A, ST_RD_D:       d = 2'b01;
         ST_RD_B, ST_RD_C:       d = 2'b11;
         default:                d = 2'b11;
      endcase
      return d;
   endfunction

   // Synchronise the bus lines and remember how long each enable has been released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync_q <= {SYNC_STAGES{1'b1}};
         sda_sync_q <= {SYNC_STAGES{1'b1}};
         scl_rel_q  <= {SYNC_STAGES{1'b1}};
         sda_rel_q  <= {SYNC_STAGES{1'b1}};
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], bus.scl_i};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], bus.sda_i};
         scl_rel_q  <= {scl_rel_q[SYNC_STAGES-2:0], scl_oen_q};
         sda_rel_q  <= {sda_rel_q[SYNC_STAGES-2:0], sda_oen_q};
      end
   end

   assign scl_s = scl_sync_q[SYNC_STAGES-1];
   assign sda_s = sda_sync_q[SYNC_STAGES-1];

   // A line read back low only means something once our own release has had
   // time to travel through the synchroniser.
   assign scl_settled_s = scl_oen_q & (&scl_rel_q);
   assign sda_settled_s = sda_oen_q & (&sda_rel_q);

   assign phase_bc_s  = state_q inside {ST_START_B, ST_START_C, ST_STOP_B, ST_STOP_C,
                                        ST_WR_B, ST_WR_C, ST_RD_B, ST_RD_C};
   assign freeze_s    = phase_bc_s & scl_settled_s & ~scl_s;
   assign tick_s      = (state_q != ST_IDLE) && (cnt_q == 16'd0) && !freeze_s;
   assign arb_lost_s  = ((state_q == ST_WR_B) || (state_q == ST_WR_C)) && txd_q &&
                        sda_settled_s && !sda_s;
   assign cmd_valid_s = bus.bit_cmd_i inside {CMD_START, CMD_STOP, CMD_WRITE, CMD_READ};
   assign accept_s    = (state_q == ST_IDLE) && !ack_q && cmd_valid_s;

   // Next-state, prescale counter and next values of all registered outputs.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      txd_d     = txd_q;
      rxd_d     = rxd_q;
      ack_d     = 1'b0;
      al_d      = 1'b0;
      scl_oen_d = scl_oen_q;
      sda_oen_d = sda_oen_q;

      if (state_q == ST_IDLE) begin
         if (accept_s) begin
            state_d = first_state(bus.bit_cmd_i);
            cnt_d   = bus.clk_cnt_i;
            txd_d   = bus.bit_txd_i;
         end else begin
            cnt_d = 16'd0;
         end
      end else if (arb_lost_s) begin
         state_d = ST_IDLE;
         cnt_d   = 16'd0;
         al_d    = 1'b1;
      end else if (tick_s) begin
         state_d = next_phase(state_q);
         cnt_d   = bus.clk_cnt_i;
         if ((state_q == ST_WR_C) || (state_q == ST_RD_C)) begin
            rxd_d = sda_s;
         end else begin
            rxd_d = rxd_q;
         end
         if (state_q inside {ST_START_D, ST_STOP_D, ST_WR_D, ST_RD_D}) begin
            ack_d = 1'b1;
            cnt_d = 16'd0;
         end else begin
            ack_d = 1'b0;
         end
      end else if (freeze_s) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q - 16'd1;
      end

      // Lines follow the phase being entered; IDLE keeps the last levels.
      if (al_d) begin
         scl_oen_d = 1'b1;
         sda_oen_d = 1'b1;
      end else if (state_d != ST_IDLE) begin
         {scl_oen_d, sda_oen_d} = line_drive(state_d, txd_d);
      end else begin
         scl_oen_d = scl_oen_q;
         sda_oen_d = sda_oen_q;
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers; reset releases the lines without waiting for clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 16'd0;
         txd_q     <= 1'b0;
         rxd_q     <= 1'b0;
         ack_q     <= 1'b0;
         al_q      <= 1'b0;
         busy_q    <= 1'b0;
         scl_oen_q <= 1'b1;
         sda_oen_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         txd_q     <= txd_d;
         rxd_q     <= rxd_d;
         ack_q     <= ack_d;
         al_q      <= al_d;
         busy_q    <= busy_d;
         scl_oen_q <= scl_oen_d;
         sda_oen_q <= sda_oen_d;
      end
   end

   assign bus.bit_ack_o = ack_q;
   assign bus.bit_rxd_o = rxd_q;
   assign bus.i2c_al_o  = al_q;
   assign bus.busy_o    = busy_q;
   assign bus.scl_oen_o = scl_oen_q;
   assign bus.sda_oen_o = sda_oen_q;

endmodule

// File: tb/tb_i2c_master_bit_ctrl.sv
// Self-checking bench for i2c_master_bit_ctrl. Expected line levels, busy/ack
// timing and received bits come from the phase tables and cycle arithmetic.
module tb_i2c_master_bit_ctrl;

   localparam logic [3:0] CMD_NOP   = 4'b0000;
   localparam logic [3:0] CMD_START = 4'b0001;
   localparam logic [3:0] CMD_STOP  = 4'b0010;
   localparam logic [3:0] CMD_WRITE = 4'b0100;
   localparam logic [3:0] CMD_READ  = 4'b1000;

   logic clk      = 1'b0;
   logic rst_n    = 1'b1;
   logic scl_hold = 1'b0;   // slave stretching SCL
   logic sda_pull = 1'b0;   // slave pulling SDA low
   logic exp_rxd  = 1'b0;
   int   vectors  = 0;
   int   errors   = 0;

   i2c_master_bit_ctrl_if bif ();

   i2c_master_bit_ctrl #(.SYNC_STAGES(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif)
   );

   always #5 clk = ~clk;

   // Wired-AND bus: master enable and slave pull-down.
   assign bif.scl_i = bif.scl_oen_o & ~scl_hold;
   assign bif.sda_i = bif.sda_oen_o & ~sda_pull;

   // {scl, sda} released (1) / low (0) for each command phase.
   function automatic logic [1:0] exp_lines(input logic [3:0] cmd, input int phase, input logic txd);
      logic [1:0] v;
      v = 2'b11;
      case (cmd)
         CMD_START: case (phase) 0: v = 2'b11; 1: v = 2'b11; 2: v = 2'b10; default: v = 2'b00; endcase
         CMD_STOP:  case (phase) 0: v = 2'b00; 1: v = 2'b10; 2: v = 2'b10; default: v = 2'b11; endcase
         CMD_WRITE: v = {(phase == 1 || phase == 2), txd};
         CMD_READ:  v = {(phase == 1 || phase == 2), 1'b1};
         default:   v = 2'b11;
      endcase
      return v;
   endfunction

   // Issue one command and check every cycle up to one past its ack.
   task automatic apply_cmd(input logic [3:0] cmd, input logic txd, input logic [15:0] n,
                            input logic pull, input int stretch, input string tag);
      int plen, b1, b2, b3, b4, phase;
      logic [1:0] want;
      plen = int'(n) + 1;
      b1 = plen;
      b2 = 2 * plen + stretch;
      b3 = b2 + plen;
      b4 = b3 + plen;
      sda_pull = pull;
      scl_hold = 1'b0;
      repeat (4) @(negedge clk);
      bif.clk_cnt_i = n;
      bif.bit_txd_i = txd;
      bif.bit_cmd_i = cmd;
      @(posedge clk);
      for (int k = 0; k <= b4 + 1; k++) begin
         @(negedge clk);
         if (k == 0) begin
            bif.bit_cmd_i = CMD_NOP;
            bif.bit_txd_i = ~txd;
         end
         if (stretch > 0 && k == b1) scl_hold = 1'b1;
         if (stretch > 0 && k == b1 + stretch) scl_hold = 1'b0;
         if (k < b1) phase = 0;
         else if (k < b2) phase = 1;
         else if (k < b3) phase = 2;
         else phase = 3;
         want = exp_lines(cmd, phase, txd);
         vectors++;
         if (bif.scl_oen_o !== want[1]) begin
            errors++;
            $display("FAIL %s scl_oen k=%0d: got %b expected %b", tag, k, bif.scl_oen_o, want[1]);
         end
         vectors++;
         if (bif.sda_oen_o !== want[0]) begin
            errors++;
            $display("FAIL %s sda_oen k=%0d: got %b expected %b", tag, k, bif.sda_oen_o, want[0]);
         end
         vectors++;
         if (bif.busy_o !== (k < b4)) begin
            errors++;
            $display("FAIL %s busy k=%0d: got %b expected %b", tag, k, bif.busy_o, (k < b4));
         end
         vectors++;
         if (bif.bit_ack_o !== (k == b4)) begin
            errors++;
            $display("FAIL %s ack k=%0d: got %b expected %b", tag, k, bif.bit_ack_o, (k == b4));
         end
         vectors++;
         if (bif.i2c_al_o !== 1'b0) begin
            errors++;
            $display("FAIL %s al k=%0d: got %b expected 0", tag, k, bif.i2c_al_o);
         end
      end
      if (cmd == CMD_READ) exp_rxd = ~pull;
      else if (cmd == CMD_WRITE) exp_rxd = txd & ~pull;
      vectors++;
      if (bif.bit_rxd_o !== exp_rxd) begin
         errors++;
         $display("FAIL %s rxd: got %b expected %b", tag, bif.bit_rxd_o, exp_rxd);
      end
   endtask

   task automatic test_reset();
      bif.clk_cnt_i = 16'd0;
      bif.bit_cmd_i = CMD_NOP;
      bif.bit_txd_i = 1'b0;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({bif.scl_oen_o, bif.sda_oen_o} !== 2'b11) begin
         errors++;
         $display("FAIL reset lines: got %b expected 11", {bif.scl_oen_o, bif.sda_oen_o});
      end
      vectors++;
      if ({bif.bit_ack_o, bif.bit_rxd_o, bif.i2c_al_o, bif.busy_o} !== 4'b0000) begin
         errors++;
         $display("FAIL reset status: got %b expected 0000",
                  {bif.bit_ack_o, bif.bit_rxd_o, bif.i2c_al_o, bif.busy_o});
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if ({bif.busy_o, bif.scl_oen_o, bif.sda_oen_o} !== 3'b011) begin
         errors++;
         $display("FAIL post-reset idle: got %b expected 011", {bif.busy_o, bif.scl_oen_o, bif.sda_oen_o});
      end
   endtask

   task automatic test_start();
      apply_cmd(CMD_START, 1'b0, 16'd3, 1'b0, 0, "start_n3");
   endtask

   task automatic test_write_pair();
      apply_cmd(CMD_WRITE, 1'b1, 16'd0, 1'b0, 0, "write1_n0");
      apply_cmd(CMD_WRITE, 1'b0, 16'd0, 1'b1, 0, "write0_n0");
   endtask

   // READ held across the ack cycle: exactly one further READ, accepted after ack.
   task automatic test_back_to_back();
      int acks;
      acks = 0;
      sda_pull = 1'b0;
      repeat (4) @(negedge clk);
      bif.clk_cnt_i = 16'd1;
      bif.bit_cmd_i = CMD_READ;
      @(posedge clk);
      for (int k = 0; k <= 20; k++) begin
         @(negedge clk);
         if (bif.bit_ack_o === 1'b1) acks++;
         vectors++;
         if (bif.sda_oen_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b sda driven k=%0d: got %b expected 1", k, bif.sda_oen_o);
         end
         if (k == 8 || k == 18) begin
            vectors++;
            if (bif.bit_ack_o !== 1'b1) begin
               errors++;
               $display("FAIL b2b ack k=%0d: got %b expected 1", k, bif.bit_ack_o);
            end
         end
         if (k == 9 || k >= 19) begin
            vectors++;
            if (bif.busy_o !== 1'b0) begin
               errors++;
               $display("FAIL b2b busy k=%0d: got %b expected 0", k, bif.busy_o);
            end
         end
         if (k == 10) begin
            vectors++;
            if (bif.busy_o !== 1'b1) begin
               errors++;
               $display("FAIL b2b second accept k=%0d: got %b expected 1", k, bif.busy_o);
            end
            bif.bit_cmd_i = CMD_NOP;
         end
      end
      vectors++;
      if (acks != 2) begin
         errors++;
         $display("FAIL b2b ack count: got %0d expected 2", acks);
      end
      exp_rxd = 1'b1;
      vectors++;
      if (bif.bit_rxd_o !== exp_rxd) begin
         errors++;
         $display("FAIL b2b rxd: got %b expected %b", bif.bit_rxd_o, exp_rxd);
      end
   endtask

   task automatic test_stretch();
      apply_cmd(CMD_READ, 1'b0, 16'd2, 1'b0, 10, "stretch10");
   endtask

   task automatic test_arbitration();
      int al_cnt, ack_cnt, first_al;
      logic seen;
      al_cnt = 0; ack_cnt = 0; first_al = -1; seen = 1'b0;
      sda_pull = 1'b0;
      repeat (4) @(negedge clk);
      bif.clk_cnt_i = 16'd2;
      bif.bit_txd_i = 1'b1;
      bif.bit_cmd_i = CMD_WRITE;
      @(posedge clk);
      for (int k = 0; k <= 20; k++) begin
         @(negedge clk);
         if (k == 0) bif.bit_cmd_i = CMD_NOP;
         if (k == 3) sda_pull = 1'b1;   // phase B begins here
         if (bif.bit_ack_o === 1'b1) ack_cnt++;
         if (bif.i2c_al_o === 1'b1) begin
            al_cnt++;
            if (!seen) first_al = k;
            seen = 1'b1;
         end
         if (seen) begin
            vectors++;
            if ({bif.busy_o, bif.scl_oen_o, bif.sda_oen_o} !== 3'b011) begin
               errors++;
               $display("FAIL arb release k=%0d: got %b expected 011",
                        k, {bif.busy_o, bif.scl_oen_o, bif.sda_oen_o});
            end
         end
      end
      sda_pull = 1'b0;
      vectors++;
      if (al_cnt != 1) begin
         errors++;
         $display("FAIL arb al pulse count: got %0d expected 1", al_cnt);
      end
      vectors++;
      if (first_al < 4 || first_al > 10) begin
         errors++;
         $display("FAIL arb al timing: got k=%0d expected within 4..10", first_al);
      end
      vectors++;
      if (ack_cnt != 0) begin
         errors++;
         $display("FAIL arb ack count: got %0d expected 0", ack_cnt);
      end
      vectors++;
      if (bif.bit_rxd_o !== exp_rxd) begin
         errors++;
         $display("FAIL arb rxd: got %b expected %b", bif.bit_rxd_o, exp_rxd);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 16; i++) begin
         logic [3:0]  c;
         logic        t;
         logic        p;
         logic [15:0] n;
         case ($urandom_range(0, 3))
            0:       c = CMD_START;
            1:       c = CMD_STOP;
            2:       c = CMD_WRITE;
            default: c = CMD_READ;
         endcase
         t = 1'($urandom);
         n = 16'($urandom_range(0, 4));
         p = 1'b0;
         if (c == CMD_READ) p = 1'($urandom);
         else if (c == CMD_WRITE && t == 1'b0) p = 1'($urandom);
         apply_cmd(c, t, n, p, 0, "random");
      end
      sda_pull = 1'b0;
   endtask

   task automatic test_ignore_invalid();
      logic [3:0] codes [4];
      codes[0] = 4'b0011; codes[1] = 4'b1111; codes[2] = 4'b0000; codes[3] = 4'b0110;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         bif.bit_cmd_i = codes[i];
         repeat (3) begin
            @(negedge clk);
            vectors++;
            if ({bif.busy_o, bif.bit_ack_o} !== 2'b00) begin
               errors++;
               $display("FAIL invalid cmd %b: got busy/ack %b expected 00", codes[i], {bif.busy_o, bif.bit_ack_o});
            end
         end
      end
      bif.bit_cmd_i = CMD_NOP;
   endtask

   task automatic test_reset_mid_stop();
      int acks;
      acks = 0;
      sda_pull = 1'b0;
      repeat (4) @(negedge clk);
      bif.clk_cnt_i = 16'd2;
      bif.bit_cmd_i = CMD_STOP;
      @(posedge clk);
      @(negedge clk);
      bif.bit_cmd_i = CMD_NOP;
      repeat (4) @(negedge clk);   // phase B: SCL released, SDA low
      vectors++;
      if ({bif.scl_oen_o, bif.sda_oen_o} !== 2'b10) begin
         errors++;
         $display("FAIL stop phase B lines: got %b expected 10", {bif.scl_oen_o, bif.sda_oen_o});
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({bif.scl_oen_o, bif.sda_oen_o, bif.busy_o} !== 3'b110) begin
         errors++;
         $display("FAIL async reset release: got %b expected 110", {bif.scl_oen_o, bif.sda_oen_o, bif.busy_o});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bif.bit_ack_o === 1'b1) acks++;
         vectors++;
         if ({bif.busy_o, bif.scl_oen_o, bif.sda_oen_o} !== 3'b011) begin
            errors++;
            $display("FAIL after reset k=%0d: got %b expected 011", k, {bif.busy_o, bif.scl_oen_o, bif.sda_oen_o});
         end
      end
      vectors++;
      if (acks != 0) begin
         errors++;
         $display("FAIL aborted stop ack count: got %0d expected 0", acks);
      end
      exp_rxd = 1'b0;
      vectors++;
      if (bif.bit_rxd_o !== exp_rxd) begin
         errors++;
         $display("FAIL rxd after reset: got %b expected %b", bif.bit_rxd_o, exp_rxd);
      end
   endtask

   initial begin
      test_reset();
      test_start();
      test_write_pair();
      test_back_to_back();
      test_stretch();
      test_arbitration();
      test_random();
      test_ignore_invalid();
      test_reset_mid_stop();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
      $fatal(1, "time limit");
   end

endmodule
